// File: rtl/ex_muldiv_pkg.sv
// Shared encodings for the iterative RV32M multiply/divide unit.
package ex_muldiv_pkg;

  localparam logic [2:0] FnMul    = 3'b000;
  localparam logic [2:0] FnMulh   = 3'b001;
  localparam logic [2:0] FnMulhsu = 3'b010;
  localparam logic [2:0] FnMulhu  = 3'b011;
  localparam logic [2:0] FnDiv    = 3'b100;
  localparam logic [2:0] FnDivu   = 3'b101;
  localparam logic [2:0] FnRem    = 3'b110;
  localparam logic [2:0] FnRemu   = 3'b111;

  typedef enum logic [1:0] {
    MdIdle,
    MdCalc,
    MdDone
  } md_state_e;

endpackage

// File: rtl/ex_muldiv.sv
// Iterative RV32M multiply/divide unit for the EX stage: one bit per cycle,
// stalls ID/EX while busy and emits a one-cycle registered result.
module ex_muldiv
  import ex_muldiv_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] reg1,
  input  logic [XLEN-1:0] reg2,
  input  logic [4:0]      rd_in,
  input  logic            rd_enable_in,
  input  logic            clear,
  output logic            stall_req,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out,
  output logic            rd_enable_out
);

  localparam int unsigned CntW = $clog2(XLEN);
  localparam int unsigned AccW = 2 * XLEN;
  localparam logic [XLEN-1:0] MinInt = {1'b1, {(XLEN-1){1'b0}}};

  md_state_e       state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      op_q, op_d;
  logic [4:0]      rd_q, rd_d;
  logic            rd_en_q, rd_en_d;
  logic            neg_q, neg_d;
  logic [XLEN-1:0] opb_q, opb_d;
  logic [AccW-1:0] acc_q, acc_d;
  logic            done_q, done_d;
  logic [XLEN-1:0] result_q, result_d;
  logic [4:0]      rd_out_q, rd_out_d;
  logic            rd_en_out_q, rd_en_out_d;

  // Operand conditioning for a new instruction
  logic            signed1, signed2, sgn1, sgn2, start_neg;
  logic [XLEN-1:0] abs1, abs2, special_res;
  logic            div_by_zero, overflow;

  always_comb begin
    signed1     = (funct3 == FnMul) || (funct3 == FnMulh) || (funct3 == FnMulhsu) ||
                  (funct3 == FnDiv) || (funct3 == FnRem);
    signed2     = (funct3 == FnMul) || (funct3 == FnMulh) || (funct3 == FnDiv) ||
                  (funct3 == FnRem);
    sgn1        = signed1 && reg1[XLEN-1];
    sgn2        = signed2 && reg2[XLEN-1];
    abs1        = sgn1 ? -reg1 : reg1;
    abs2        = sgn2 ? -reg2 : reg2;
    start_neg   = 1'b0;
    case (funct3)
      FnMul, FnMulh, FnDiv: start_neg = sgn1 ^ sgn2;
      FnMulhsu, FnRem:      start_neg = sgn1;
      default:              start_neg = 1'b0;
    endcase
    div_by_zero = funct3[2] && (reg2 == '0);
    overflow    = ((funct3 == FnDiv) || (funct3 == FnRem)) && (reg1 == MinInt) && (reg2 == '1);
    if (div_by_zero) special_res = funct3[1] ? reg1 : '1;
    else             special_res = funct3[1] ? '0 : MinInt;
  end

  // One shift-add or restoring-divide step on the accumulator
  logic [XLEN-1:0] mul_addend;
  logic [XLEN:0]   mul_sum, div_rem, div_diff;
  logic [AccW-1:0] step, prod_fix;
  logic [XLEN-1:0] quo, rem, fin_res;

  always_comb begin
    mul_addend = acc_q[0] ? opb_q : '0;
    mul_sum    = {1'b0, acc_q[AccW-1:XLEN]} + {1'b0, mul_addend};
    div_rem    = acc_q[AccW-1:XLEN-1];
    div_diff   = div_rem - {1'b0, opb_q};
    if (op_q[2]) begin
      step = div_diff[XLEN] ? {div_rem[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                            : {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    end else begin
      step = {mul_sum, acc_q[XLEN-1:1]};
    end
    prod_fix = neg_q ? -step : step;
    quo      = step[XLEN-1:0];
    rem      = step[AccW-1:XLEN];
    case (op_q)
      FnMul:                     fin_res = prod_fix[XLEN-1:0];
      FnMulh, FnMulhsu, FnMulhu: fin_res = prod_fix[AccW-1:XLEN];
      FnDiv, FnDivu:             fin_res = neg_q ? -quo : quo;
      default:                   fin_res = neg_q ? -rem : rem;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    rd_d        = rd_q;
    rd_en_d     = rd_en_q;
    neg_d       = neg_q;
    opb_d       = opb_q;
    acc_d       = acc_q;
    done_d      = 1'b0;
    result_d    = result_q;
    rd_out_d    = rd_out_q;
    rd_en_out_d = 1'b0;
    stall_req   = 1'b0;
    unique case (state_q)
      MdIdle: begin
        if (start && !clear) begin
          stall_req = 1'b1;
          op_d      = funct3;
          rd_d      = rd_in;
          rd_en_d   = rd_enable_in;
          if (div_by_zero || overflow) begin
            state_d     = MdDone;
            done_d      = 1'b1;
            result_d    = special_res;
            rd_out_d    = rd_in;
            rd_en_out_d = rd_enable_in;
          end else begin
            state_d = MdCalc;
            cnt_d   = '0;
            neg_d   = start_neg;
            // Divisor or multiplicand sits in opb; the accumulator low half
            // holds the dividend or multiplier.
            opb_d   = funct3[2] ? abs2 : abs1;
            acc_d   = {{XLEN{1'b0}}, (funct3[2] ? abs1 : abs2)};
          end
        end
      end
      MdCalc: begin
        stall_req = 1'b1;
        acc_d     = step;
        cnt_d     = cnt_q + 1'b1;
        if (cnt_q == CntW'(XLEN - 1)) begin
          state_d     = MdDone;
          done_d      = 1'b1;
          result_d    = fin_res;
          rd_out_d    = rd_q;
          rd_en_out_d = rd_en_q;
        end
      end
      MdDone: state_d = MdIdle;
      default: state_d = MdIdle;
    endcase
    if (clear) begin
      state_d     = MdIdle;
      done_d      = 1'b0;
      rd_en_out_d = 1'b0;
      result_d    = result_q;
      rd_out_d    = rd_out_q;
    end
    if (rst) stall_req = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= MdIdle;
      cnt_q       <= '0;
      op_q        <= '0;
      rd_q        <= '0;
      rd_en_q     <= 1'b0;
      neg_q       <= 1'b0;
      opb_q       <= '0;
      acc_q       <= '0;
      done_q      <= 1'b0;
      result_q    <= '0;
      rd_out_q    <= '0;
      rd_en_out_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      rd_q        <= rd_d;
      rd_en_q     <= rd_en_d;
      neg_q       <= neg_d;
      opb_q       <= opb_d;
      acc_q       <= acc_d;
      done_q      <= done_d;
      result_q    <= result_d;
      rd_out_q    <= rd_out_d;
      rd_en_out_q <= rd_en_out_d;
    end
  end

  assign done          = done_q;
  assign result        = result_q;
  assign rd_out        = rd_out_q;
  assign rd_enable_out = rd_en_out_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Self-checking bench for ex_muldiv: directed RV32M cases, random ops against
// a plain-arithmetic reference, flush, mid-op reset and back-to-back issue.
module tb_ex_muldiv;

  logic        clk = 1'b0;
  logic        rst, start, clear, rd_enable_in;
  logic [2:0]  funct3;
  logic [31:0] reg1, reg2;
  logic [4:0]  rd_in;
  logic        stall_req, done, rd_enable_out;
  logic [31:0] result;
  logic [4:0]  rd_out;

  int checks = 0;
  int failures = 0;

  ex_muldiv #(.XLEN(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .funct3       (funct3),
    .reg1         (reg1),
    .reg2         (reg2),
    .rd_in        (rd_in),
    .rd_enable_in (rd_enable_in),
    .clear        (clear),
    .stall_req    (stall_req),
    .done         (done),
    .result       (result),
    .rd_out       (rd_out),
    .rd_enable_out(rd_enable_out)
  );

  always #5 clk = ~clk;

  // Reference: RV32M semantics from 64-bit integer arithmetic
  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a,
                                        input logic [31:0] b);
    longint sa, sb;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (f)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * longint'({32'b0, b}); return p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        p = sa / sb; return p[31:0];
      end
      3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 32'd0) return a;
        p = sa % sb; return p[31:0];
      end
      default: return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  function automatic int model_lat(input logic [2:0] f, input logic [31:0] a,
                                   input logic [31:0] b);
    if (f[2] && b == 32'd0) return 1;
    if ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      default: return 32'($urandom);
    endcase
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Issue one op (start held until done), report what the DUT did
  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic rden,
                       output logic [31:0] res, output int lat, output int stall_hi,
                       output logic stall_at_done, output logic [4:0] rdo,
                       output logic rdeo);
    next_cycle();
    start = 1'b1; funct3 = f; reg1 = a; reg2 = b; rd_in = rd; rd_enable_in = rden;
    lat = -1; stall_hi = 0; res = 'x; rdo = 'x; rdeo = 1'bx; stall_at_done = 1'bx;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (done) begin
        lat = c; res = result; rdo = rd_out; rdeo = rd_enable_out;
        stall_at_done = stall_req;
        break;
      end
      if (stall_req) stall_hi++;
    end
    next_cycle();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; clear = 1'b0; funct3 = 3'd0;
    reg1 = 32'd5; reg2 = 32'd6; rd_in = 5'd3; rd_enable_in = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks += 5;
    if (stall_req !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", stall_req); end
    if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    if (result !== 32'd0) begin failures++; $display("FAIL reset_result got=%h exp=0", result); end
    if (rd_out !== 5'd0) begin failures++; $display("FAIL reset_rd got=%0d exp=0", rd_out); end
    if (rd_enable_out !== 1'b0) begin
      failures++; $display("FAIL reset_rden got=%b exp=0", rd_enable_out);
    end
    next_cycle();
    rst = 1'b0; start = 1'b0;
  endtask

  typedef struct {
    logic [2:0] f; logic [31:0] a; logic [31:0] b; logic [31:0] exp; int lat;
  } vec_t;

  task automatic test_directed();
    vec_t v[13];
    logic [31:0] res; int lat, sh; logic sd; logic [4:0] rdo; logic rdeo;
    v[0]  = '{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 33};
    v[1]  = '{3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 33};
    v[2]  = '{3'd3, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 33};
    v[3]  = '{3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 33};
    v[4]  = '{3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 33};
    v[5]  = '{3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 33};
    v[6]  = '{3'd5, 32'd100,        32'd7,         32'd14,        33};
    v[7]  = '{3'd7, 32'd100,        32'd7,         32'd2,         33};
    v[8]  = '{3'd5, 32'd5,          32'd0,         32'hFFFF_FFFF, 1};
    v[9]  = '{3'd7, 32'd5,          32'd0,         32'd5,         1};
    v[10] = '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1};
    v[11] = '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1};
    v[12] = '{3'd6, 32'hFFFF_FFF9,  32'd0,         32'hFFFF_FFF9, 1};
    foreach (v[i]) begin
      issue(v[i].f, v[i].a, v[i].b, 5'(i + 1), 1'b1, res, lat, sh, sd, rdo, rdeo);
      checks += 6;
      if (res !== v[i].exp) begin
        failures++; $display("FAIL dir%0d_result got=%h exp=%h", i, res, v[i].exp);
      end
      if (lat != v[i].lat) begin
        failures++; $display("FAIL dir%0d_latency got=%0d exp=%0d", i, lat, v[i].lat);
      end
      if (sh != v[i].lat) begin
        failures++; $display("FAIL dir%0d_stall_cycles got=%0d exp=%0d", i, sh, v[i].lat);
      end
      if (sd !== 1'b0) begin failures++; $display("FAIL dir%0d_stall_at_done got=%b exp=0", i, sd); end
      if (rdo !== 5'(i + 1)) begin
        failures++; $display("FAIL dir%0d_rd got=%0d exp=%0d", i, rdo, i + 1);
      end
      if (rdeo !== 1'b1) begin failures++; $display("FAIL dir%0d_rden got=%b exp=1", i, rdeo); end
    end
    // Idle with start low: pulse gone, result held
    @(negedge clk);
    checks += 3;
    if (done !== 1'b0) begin failures++; $display("FAIL idle_done got=%b exp=0", done); end
    if (rd_enable_out !== 1'b0) begin failures++; $display("FAIL idle_rden got=%b exp=0", rd_enable_out); end
    if (result !== v[12].exp) begin
      failures++; $display("FAIL idle_hold got=%h exp=%h", result, v[12].exp);
    end
  endtask

  task automatic test_random();
    logic [2:0] f; logic [31:0] a, b, res; int lat, sh; logic sd; logic [4:0] rd, rdo;
    logic rden, rdeo;
    for (int n = 0; n < 40; n++) begin
      f = 3'($urandom_range(0, 7)); a = pick(); b = pick();
      rd = 5'($urandom); rden = 1'($urandom);
      issue(f, a, b, rd, rden, res, lat, sh, sd, rdo, rdeo);
      checks += 4;
      if (res !== model(f, a, b)) begin
        failures++;
        $display("FAIL rnd%0d_result f=%0d a=%h b=%h got=%h exp=%h", n, f, a, b, res, model(f, a, b));
      end
      if (lat != model_lat(f, a, b)) begin
        failures++; $display("FAIL rnd%0d_latency got=%0d exp=%0d", n, lat, model_lat(f, a, b));
      end
      if (rdo !== rd) begin failures++; $display("FAIL rnd%0d_rd got=%0d exp=%0d", n, rdo, rd); end
      if (rdeo !== rden) begin failures++; $display("FAIL rnd%0d_rden got=%b exp=%b", n, rdeo, rden); end
    end
  endtask

  task automatic test_clear();
    int pulses;
    int done_cyc;
    logic [31:0] res;
    // Flush at cycle 10, nothing follows
    next_cycle();
    start = 1'b1; funct3 = 3'd4; reg1 = 32'd1000; reg2 = 32'd3; rd_in = 5'd9; rd_enable_in = 1'b1;
    repeat (10) next_cycle();
    clear = 1'b1;
    next_cycle();
    clear = 1'b0; start = 1'b0;
    @(negedge clk);
    checks++;
    if (stall_req !== 1'b0) begin failures++; $display("FAIL clear_stall got=%b exp=0", stall_req); end
    pulses = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done || rd_enable_out) pulses++;
    end
    checks++;
    if (pulses != 0) begin failures++; $display("FAIL clear_no_done got=%0d exp=0", pulses); end
    // Flush at cycle 10, new MUL 3*4 accepted at cycle 11
    next_cycle();
    start = 1'b1; funct3 = 3'd4; reg1 = 32'd1000; reg2 = 32'd3;
    repeat (10) next_cycle();
    clear = 1'b1;
    next_cycle();
    clear = 1'b0; funct3 = 3'd0; reg1 = 32'd3; reg2 = 32'd4; rd_in = 5'd12;
    done_cyc = -1; pulses = 0; res = 'x;
    for (int c = 11; c < 60; c++) begin
      @(negedge clk);
      if (done) begin
        pulses++;
        if (done_cyc < 0) begin done_cyc = c; res = result; end
      end
      next_cycle();
      if (c >= 44) start = 1'b0;
    end
    checks += 3;
    if (done_cyc != 44) begin failures++; $display("FAIL clear_restart_cycle got=%0d exp=44", done_cyc); end
    if (res !== 32'd12) begin failures++; $display("FAIL clear_restart_result got=%h exp=c", res); end
    if (pulses != 1) begin failures++; $display("FAIL clear_restart_pulses got=%0d exp=1", pulses); end
  endtask

  task automatic test_reset_mid();
    next_cycle();
    start = 1'b1; funct3 = 3'd1; reg1 = 32'h1234_5678; reg2 = 32'h9ABC_DEF0;
    rd_in = 5'd17; rd_enable_in = 1'b1;
    repeat (15) next_cycle();
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (stall_req !== 1'b0) begin failures++; $display("FAIL rstmid_stall got=%b exp=0", stall_req); end
    next_cycle();
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    checks += 4;
    if (done !== 1'b0) begin failures++; $display("FAIL rstmid_done got=%b exp=0", done); end
    if (result !== 32'd0) begin failures++; $display("FAIL rstmid_result got=%h exp=0", result); end
    if (rd_out !== 5'd0) begin failures++; $display("FAIL rstmid_rd got=%0d exp=0", rd_out); end
    if (rd_enable_out !== 1'b0) begin
      failures++; $display("FAIL rstmid_rden got=%b exp=0", rd_enable_out);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a1, b1, a2, b2, r1, r2;
    int c1, c2, pulses;
    a1 = 32'($urandom); b1 = 32'($urandom); a2 = 32'($urandom); b2 = 32'($urandom);
    c1 = -1; c2 = -1; pulses = 0; r1 = 'x; r2 = 'x;
    next_cycle();
    start = 1'b1; funct3 = 3'd0; reg1 = a1; reg2 = b1; rd_in = 5'd1; rd_enable_in = 1'b1;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (done) begin
        pulses++;
        if (c1 < 0) begin c1 = c; r1 = result; end
        else if (c2 < 0) begin c2 = c; r2 = result; end
      end
      next_cycle();
      // Start stays high through each DONE cycle; pipeline advances after it
      if (c == 33) begin reg1 = a2; reg2 = b2; rd_in = 5'd2; end
      if (c == 67) start = 1'b0;
    end
    checks += 5;
    if (pulses != 2) begin failures++; $display("FAIL b2b_pulses got=%0d exp=2", pulses); end
    if (c1 != 33) begin failures++; $display("FAIL b2b_first_cycle got=%0d exp=33", c1); end
    if (c2 != 67) begin failures++; $display("FAIL b2b_second_cycle got=%0d exp=67", c2); end
    if (r1 !== a1 * b1) begin failures++; $display("FAIL b2b_first_result got=%h exp=%h", r1, a1 * b1); end
    if (r2 !== a2 * b2) begin failures++; $display("FAIL b2b_second_result got=%h exp=%h", r2, a2 * b2); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_clear();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
